// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// data_mem_responder_pkg : shared widths, state encoding and range helper
// Rev 1.0
// ============================================================================
package data_mem_responder_pkg;

  localparam int REG_BUS_W = 32;
  localparam int SEL_W     = 4;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when every address bit above the implemented word range is zero.
  function automatic logic addr_in_range(input logic [REG_BUS_W-1:0] addr,
                                         input int                   word_aw);
    return (addr >> (word_aw + 2)) == ZERO_WORD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// data_mem_responder_if : CPU data-memory port bundle (request + response)
// Rev 1.0
// ============================================================================
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic                 ce_i;
  logic                 we_i;
  logic [REG_BUS_W-1:0] addr_i;
  logic [SEL_W-1:0]     sel_i;
  logic [REG_BUS_W-1:0] data_i;
  logic [REG_BUS_W-1:0] data_o;
  logic                 stall_o;
  logic                 ack_o;
  logic                 err_o;

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, stall_o, ack_o, err_o
  );

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, stall_o, ack_o, err_o
  );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_mem_byte_array.sv
`default_nettype none
// ============================================================================
// mem_byte_array : four byte-wide banks, per-lane write enable, registered read
// Rev 1.0
// ============================================================================
module mem_byte_array
  import data_mem_responder_pkg::*;
#(
  parameter int WORD_AW = 15
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic [SEL_W-1:0]     wr_be,
  input  wire logic                 rd_en,
  input  wire logic                 rd_zero,
  input  wire logic [WORD_AW-1:0]   addr,
  input  wire logic [REG_BUS_W-1:0] wdata,
  output logic      [REG_BUS_W-1:0] rdata
);

  logic [SEL_W-1:0][7:0] lane_rd;
  logic [REG_BUS_W-1:0]  rdata_d;
  logic [REG_BUS_W-1:0]  rdata_q;

  for (genvar i = 0; i < SEL_W; i++) begin : g_lane
    logic [7:0] bank [2**WORD_AW];

    always_ff @(posedge clk) begin
      if (wr_be[i]) begin
        bank[addr] <= wdata[8*i +: 8];
      end
    end

    assign lane_rd[i] = bank[addr];
  end

  // Out-of-range reads return zero instead of the aliased word.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = rd_zero ? ZERO_WORD : lane_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= ZERO_WORD;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : wait-state data-memory responder with byte lanes + err
// Rev 1.0
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int WORD_AW     = 15,
  parameter int WAIT_CYCLES = 2
) (
  input wire logic       clk,
  input wire logic       rst,
  data_mem_responder_if.slave bus
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [REG_BUS_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [REG_BUS_W-1:0] data_q, data_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic                 req_we;
  logic [REG_BUS_W-1:0] req_addr;
  logic [SEL_W-1:0]     req_sel;
  logic [REG_BUS_W-1:0] req_data;
  logic                 req_oor;
  logic                 commit;
  logic [SEL_W-1:0]     wr_be;
  logic                 rd_en;
  logic [REG_BUS_W-1:0] rdata;

  // With zero wait states the access commits on the latching edge, so the
  // storage must see the live request rather than the latch.
  always_comb begin
    if (state_q == ST_IDLE) begin
      req_we   = bus.we_i;
      req_addr = bus.addr_i;
      req_sel  = bus.sel_i;
      req_data = bus.data_i;
    end else begin
      req_we   = we_q;
      req_addr = addr_q;
      req_sel  = sel_q;
      req_data = data_q;
    end
    req_oor = !addr_in_range(req_addr, WORD_AW);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    commit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ce_i) begin
          we_d   = bus.we_i;
          addr_d = bus.addr_i;
          sel_d  = bus.sel_i;
          data_d = bus.data_i;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_DONE;
            commit  = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ack_d = commit;
    err_d = commit && req_oor;
  end

  // Reset on the commit edge wins over the write.
  assign wr_be = (commit && req_we && !req_oor && rst) ? req_sel : '0;
  assign rd_en = commit && !req_we && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= ZERO_WORD;
      sel_q   <= '0;
      data_q  <= ZERO_WORD;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  mem_byte_array #(
    .WORD_AW (WORD_AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_be   (wr_be),
    .rd_en   (rd_en),
    .rd_zero (req_oor),
    .addr    (req_addr[WORD_AW+1:2]),
    .wdata   (req_data),
    .rdata   (rdata)
  );

  assign bus.stall_o = rst && (((state_q == ST_IDLE) && bus.ce_i) || (state_q == ST_BUSY));
  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.data_o  = rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_data_mem_responder : checks a 0-wait and a 2-wait responder against a
// cycle-timeline model of the access protocol. Rev 1.0
// ============================================================================
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  data_mem_responder_if bus_w0 ();
  data_mem_responder_if bus_w2 ();

  data_mem_responder #(.WORD_AW(15), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus_w0)
  );
  data_mem_responder #(.WORD_AW(15), .WAIT_CYCLES(2)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus_w2)
  );

  always #5 clk = ~clk;

  int          wc [2] = '{0, 2};
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  bit          rst_at_edge = 1'b0;
  bit          active   [2];
  int          t_issue  [2];
  bit          op_we    [2];
  logic [31:0] op_addr  [2];
  logic [3:0]  op_sel   [2];
  logic [31:0] op_data  [2];
  logic [31:0] exp_data [2];
  logic [31:0] mm [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
    return a >= 32'h0002_0000;
  endfunction

  function automatic int key(input int d, input logic [31:0] a);
    return d * 32768 + int'((a >> 2) & 32'h7fff);
  endfunction

  task automatic drive(input int d, input bit ce, input bit we, input logic [31:0] a,
                       input logic [3:0] sel, input logic [31:0] dat);
    if (d == 0) begin
      bus_w0.ce_i = ce; bus_w0.we_i = we; bus_w0.addr_i = a;
      bus_w0.sel_i = sel; bus_w0.data_i = dat;
    end else begin
      bus_w2.ce_i = ce; bus_w2.we_i = we; bus_w2.addr_i = a;
      bus_w2.sel_i = sel; bus_w2.data_i = dat;
    end
  endtask

  function automatic logic [31:0] dout(input int d);
    return (d == 0) ? bus_w0.data_o : bus_w2.data_o;
  endfunction

  task automatic start(input int d, input bit we, input logic [31:0] a,
                       input logic [3:0] sel, input logic [31:0] dat);
    drive(d, 1'b1, we, a, sel, dat);
    op_we[d] = we; op_addr[d] = a; op_sel[d] = sel; op_data[d] = dat;
    t_issue[d] = cyc;
    active[d]  = 1'b1;
  endtask

  // The CPU holds the request from issue through the DONE cycle.
  task automatic access(input int d, input bit we, input logic [31:0] a,
                        input logic [3:0] sel, input logic [31:0] dat);
    start(d, we, a, sel, dat);
    repeat (wc[d] + 2) @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic read_lit(input int d, input logic [31:0] a, input logic [31:0] lit,
                          input string name);
    access(d, 1'b0, a, 4'hF, 32'h0);
    chk(name, dout(d), lit);
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = !rst;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int d = 0; d < 2; d++) begin
        bit          se, ae, ee;
        logic [31:0] word;
        int          k;
        bit          st, ak, er;
        if (rst_at_edge) begin
          active[d]   = 1'b0;
          exp_data[d] = 32'h0;
        end
        se = rst && active[d] && (cyc <= t_issue[d] + wc[d]);
        ae = active[d] && (cyc == t_issue[d] + 1 + wc[d]);
        ee = ae && is_oor(op_addr[d]);
        if (ae) begin
          k = key(d, op_addr[d]);
          if (!op_we[d]) begin
            exp_data[d] = is_oor(op_addr[d]) ? 32'h0 : mm[k];
          end else if (!is_oor(op_addr[d])) begin
            word = mm.exists(k) ? mm[k] : 32'hxxxx_xxxx;
            for (int l = 0; l < 4; l++) begin
              if (op_sel[d][l]) word[8*l +: 8] = op_data[d][8*l +: 8];
            end
            mm[k] = word;
          end
          active[d] = 1'b0;
        end
        st = (d == 0) ? bus_w0.stall_o : bus_w2.stall_o;
        ak = (d == 0) ? bus_w0.ack_o   : bus_w2.ack_o;
        er = (d == 0) ? bus_w0.err_o   : bus_w2.err_o;
        chk($sformatf("w%0d.stall", wc[d]), {31'h0, st}, {31'h0, se});
        chk($sformatf("w%0d.ack",   wc[d]), {31'h0, ak}, {31'h0, ae});
        chk($sformatf("w%0d.err",   wc[d]), {31'h0, er}, {31'h0, ee});
        chk($sformatf("w%0d.data",  wc[d]), dout(d), exp_data[d]);
      end
    end
  end

  initial begin
    drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;

    // Two wait states: full word, then byte-lane merges.
    access(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    read_lit(1, 32'h10, 32'hDEADBEEF, "lit.full_word");
    access(1, 1'b1, 32'h10, 4'b0001, 32'h000000AA);
    access(1, 1'b1, 32'h10, 4'b0010, 32'h0000BB00);
    read_lit(1, 32'h10, 32'hDEADBBAA, "lit.lane_merge");

    // Out of range: zero read data, and a write must not alias into range.
    read_lit(1, 32'h0002_0000, 32'h0, "lit.oor_read");
    access(1, 1'b1, 32'h0002_0010, 4'hF, 32'hFFFFFFFF);
    read_lit(1, 32'h10, 32'hDEADBBAA, "lit.oor_write_noalias");
    read_lit(1, 32'h13, 32'hDEADBBAA, "lit.low_bits_ignored");
    access(1, 1'b1, 32'h10, 4'b0000, 32'h01234567);
    read_lit(1, 32'h10, 32'hDEADBBAA, "lit.sel_zero");

    // Reset during BUSY discards the pending write.
    access(1, 1'b1, 32'h20, 4'hF, 32'h12345678);
    start(1, 1'b1, 32'h20, 4'hF, 32'h55555555);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    read_lit(1, 32'h20, 32'h12345678, "lit.reset_in_busy");

    // Zero wait states: back-to-back write then read of the same word.
    access(0, 1'b1, 32'h40, 4'hF, 32'h11223344);
    read_lit(0, 32'h40, 32'h11223344, "lit.w0_raw");
    access(0, 1'b1, 32'h44, 4'b1100, 32'hCAFE0000);
    access(0, 1'b1, 32'h44, 4'b0011, 32'h0000F00D);
    read_lit(0, 32'h44, 32'hCAFEF00D, "lit.w0_lanes");
    read_lit(0, 32'h0002_0040, 32'h0, "lit.w0_oor");
    read_lit(0, 32'h40, 32'h11223344, "lit.w0_reread");

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
